// File: rtl/id_scoreboard_pkg.sv
// ============================================================================
// Module   : id_scoreboard_pkg
// Purpose  : Shared types and latency helpers for the ID-stage scoreboard.
//            Macro SCOREBOARD_FORWARDING_EN selects forwarding-aware RAW latencies.
// Revision : 1.0
// ============================================================================
`default_nettype none

package id_scoreboard_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ALU  = 2'd1,
        OP_LOAD = 2'd2,
        OP_MUL  = 2'd3
    } op_class_t;

    // Cycles a dependent instruction must wait after its producer issues.
    function automatic int raw_lat(input op_class_t cls, input int wb_lat, input int mul_lat);
        int v;
        v = 0;
`ifdef SCOREBOARD_FORWARDING_EN
        case (cls)
            OP_ALU:  v = 0;
            OP_LOAD: v = 1;
            OP_MUL:  v = mul_lat;
            default: v = 0;
        endcase
        if (wb_lat < 0) v = 0;
`else
        case (cls)
            OP_ALU,
            OP_LOAD: v = wb_lat;
            OP_MUL:  v = wb_lat + mul_lat - 1;
            default: v = 0;
        endcase
`endif
        return v;
    endfunction

    // Issue-to-writeback distance; zero means the class never writes back.
    function automatic int wb_off(input op_class_t cls, input int wb_lat, input int mul_lat);
        int o;
        case (cls)
            OP_ALU,
            OP_LOAD: o = wb_lat;
            OP_MUL:  o = wb_lat + mul_lat - 1;
            default: o = 0;
        endcase
        return o;
    endfunction

endpackage : id_scoreboard_pkg

`default_nettype wire

// File: rtl/id_scoreboard_wb_port_reserve.sv
// ============================================================================
// Module   : id_scoreboard_wb_port_reserve
// Purpose  : Write-back port reservation shift register with conflict query.
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_scoreboard_wb_port_reserve
    import id_scoreboard_pkg::*;
#(
    parameter int WB_LAT  = 3,
    parameter int MUL_LAT = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  op_class_t cls,
    input  logic      fire,
    output logic      conflict
);

    localparam int C_RESV_W = WB_LAT + MUL_LAT;

    logic [C_RESV_W-1:0] r_resv;
    logic [C_RESV_W-1:0] w_mask;
    int                  w_off;

    assign w_off = wb_off(cls, WB_LAT, MUL_LAT);

    always_comb begin
        w_mask = '0;
        if (w_off > 0) begin
            w_mask = C_RESV_W'(1) << (w_off - 1);
        end
    end

    assign conflict = |(r_resv & w_mask);

    // Bit i names the write-back slot i+1 cycles ahead, so a fresh claim is
    // merged before the shift that ages the whole vector by one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_resv <= '0;
        end else begin
            r_resv <= (r_resv | (fire ? w_mask : '0)) >> 1;
        end
    end

endmodule : id_scoreboard_wb_port_reserve

`default_nettype wire

// File: rtl/id_scoreboard.sv
// ============================================================================
// Module   : id_scoreboard
// Purpose  : Per-register countdown scoreboard producing the ID-stage stall,
//            with MUL tracking, WB port reservation and WAW ordering.
//            Optional macro: SCOREBOARD_FORWARDING_EN (forwarding-aware release).
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int WB_LAT   = 3,
    parameter int MUL_LAT  = 4,
    parameter int CNT_W    = $clog2(WB_LAT + MUL_LAT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [IDX_W-1:0]    issue_ra_idx,
    input  logic [IDX_W-1:0]    issue_rb_idx,
    input  logic                issue_ra_used,
    input  logic                issue_rb_used,
    input  logic [IDX_W-1:0]    issue_dest_idx,
    input  logic [1:0]          issue_class,
    output logic                stall,
    output logic                issue_fire,
    output logic [NUM_REGS-1:0] busy_vec
);

    localparam logic [CNT_W-1:0] C_MUL_BUSY = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] C_MUL_REM  = CNT_W'(WB_LAT + MUL_LAT - 2);
    localparam logic [CNT_W-1:0] C_WB_LAT   = CNT_W'(WB_LAT);

    op_class_t          w_cls;
    logic               w_writer;
    logic               w_is_mul;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_raw_a;
    logic               w_raw_b;
    logic               w_wb_conf;
    logic               w_struct;
    logic               w_waw;

    logic [CNT_W-1:0]   r_mul_busy;
    logic [IDX_W-1:0]   r_mul_dest;
    logic [CNT_W-1:0]   r_mul_wb_rem;

    assign w_cls      = op_class_t'(issue_class);
    assign w_writer   = (w_cls != OP_NONE);
    assign w_is_mul   = (w_cls == OP_MUL);
    assign w_load_val = CNT_W'(raw_lat(w_cls, WB_LAT, MUL_LAT));

    // Hazard terms look only at registered state, so an instruction that
    // overwrites its own source is judged against the previous producer.
    assign w_raw_a = issue_ra_used && (issue_ra_idx != '0) && busy_vec[issue_ra_idx];
    assign w_raw_b = issue_rb_used && (issue_rb_idx != '0) && busy_vec[issue_rb_idx];

    assign w_struct = w_is_mul && (r_mul_busy != '0);

    assign w_waw = w_writer && !w_is_mul
                && (issue_dest_idx != '0)
                && (issue_dest_idx == r_mul_dest)
                && (r_mul_wb_rem >= C_WB_LAT);

    assign stall      = issue_valid && (w_raw_a || w_raw_b || w_wb_conf || w_struct || w_waw);
    assign issue_fire = issue_valid && !stall;

    id_scoreboard_wb_port_reserve #(
        .WB_LAT  (WB_LAT),
        .MUL_LAT (MUL_LAT)
    ) u_wb_port_reserve (
        .clk      (clk),
        .rst      (rst),
        .cls      (w_cls),
        .fire     (issue_fire),
        .conflict (w_wb_conf)
    );

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        if (r == 0) begin : g_zero
            assign busy_vec[r] = 1'b0;
        end else begin : g_reg
            logic [CNT_W-1:0] r_cnt;
            logic             w_load;

            assign w_load = issue_fire && w_writer && (issue_dest_idx == IDX_W'(r));

            // A same-cycle issue load takes priority over the countdown.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_cnt <= '0;
                end else if (w_load) begin
                    r_cnt <= w_load_val;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign busy_vec[r] = (r_cnt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mul_busy   <= '0;
            r_mul_dest   <= '0;
            r_mul_wb_rem <= '0;
        end else if (issue_fire && w_is_mul) begin
            r_mul_busy   <= C_MUL_BUSY;
            r_mul_dest   <= issue_dest_idx;
            r_mul_wb_rem <= C_MUL_REM;
        end else begin
            if (r_mul_busy != '0) begin
                r_mul_busy <= r_mul_busy - 1'b1;
            end
            if (r_mul_wb_rem != '0) begin
                r_mul_wb_rem <= r_mul_wb_rem - 1'b1;
            end
        end
    end

endmodule : id_scoreboard

`default_nettype wire
